// File: rtl/fetch_aligner_pkg.sv
// Shared frontend definitions for the fetch aligner.
// Holds the fetch FSM state type, the fetch block size and the packet geometry
// (instruction width, fetch width and slot count).
package fetch_aligner_pkg;

    localparam int FETCH_BYTES = 16;
    localparam int INSTR_W     = 32;
    localparam int FETCH_W     = 128;
    localparam int NUM_SLOTS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_aligner_shift.sv
// fetch_align_shift: combinational packet aligner.
// Moves the word at slot k_i down to slot 0, zero-fills the upper slots, and
// produces the matching valid mask.
//   data_i  : raw fetch block, word i in bits [32i+31:32i]
//   k_i     : word offset of the fetch PC inside the block
//   data_o  : shifted packet
//   mask_o  : per-slot valid mask (all ones shifted right by k_i)
module fetch_align_shift
    import fetch_aligner_pkg::*;
(
    input  logic [FETCH_W-1:0]   data_i,
    input  logic [1:0]           k_i,
    output logic [FETCH_W-1:0]   data_o,
    output logic [NUM_SLOTS-1:0] mask_o
);

    logic [6:0] shamt;

    always_comb begin
        shamt  = {k_i, 5'd0};
        data_o = data_i >> shamt;
        mask_o = {NUM_SLOTS{1'b1}} >> k_i;
    end

endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction fetch sequencer and packet aligner.
// Issues one 16-byte block request at a time to the I-cache, aligns the
// returned block so slot 0 holds the instruction at the fetch PC, and handles
// redirects by dropping the outstanding response.
//   clock, reset_n              : clock and async active-low reset
//   fetch_inst                  : downstream ready for a new packet
//   mem_stall                   : blocks starting a new request
//   redirect_valid/_target      : restart fetch at a new PC
//   icache_req_valid/_ready/_addr : block request handshake
//   icache_resp_valid/_data     : one-cycle response strobe and block data
//   aligned_instr/_valid, pc    : delivered packet, slot mask, PC of slot 0
//   pc_operation_done           : one-cycle pulse with each packet
//
// state | meaning
// IDLE  | no request outstanding, waiting for fetch_inst
// REQ   | request presented, waiting for the cache to accept it
// WAIT  | request accepted, waiting for the response
// KILL  | request accepted before a redirect; drop its response
module fetch_aligner #(
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int          FETCH_BYTES = fetch_aligner_pkg::FETCH_BYTES
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          fetch_inst,
    input  logic          mem_stall,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_target,
    output logic          icache_req_valid,
    input  logic          icache_req_ready,
    output logic [63:0]   icache_req_addr,
    input  logic          icache_resp_valid,
    input  logic [127:0]  icache_resp_data,
    output logic [127:0]  aligned_instr,
    output logic [3:0]    aligned_instr_valid,
    output logic [63:0]   pc,
    output logic          pc_operation_done
);
    import fetch_aligner_pkg::*;

    fetch_state_e         state_q, state_d;
    logic [63:0]          fetch_pc_q, fetch_pc_d;
    logic [FETCH_W-1:0]   instr_q;
    logic [NUM_SLOTS-1:0] valid_q;
    logic [63:0]          pc_q;
    logic                 done_q;

    logic                 req_fire;
    logic                 deliver;
    logic [63:0]          block_base;
    logic [FETCH_W-1:0]   shifted;
    logic [NUM_SLOTS-1:0] shifted_mask;

    fetch_align_shift u_shift (
        .data_i (icache_resp_data),
        .k_i    (fetch_pc_q[3:2]),
        .data_o (shifted),
        .mask_o (shifted_mask)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        deliver    = 1'b0;
        block_base = {fetch_pc_q[63:4], 4'b0};
        req_fire   = (state_q == ST_REQ) && icache_req_ready;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_target[63:2], 2'b00};
            unique case (state_q)
                ST_REQ:  state_d = req_fire ? ST_KILL : ST_IDLE;
                // A response in the redirect cycle is the outstanding one,
                // so there is nothing left to drop.
                ST_WAIT: state_d = icache_resp_valid ? ST_IDLE : ST_KILL;
                ST_KILL: state_d = icache_resp_valid ? ST_IDLE : ST_KILL;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: if (fetch_inst && !mem_stall) state_d = ST_REQ;
                ST_REQ:  if (req_fire) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (icache_resp_valid) begin
                        deliver    = 1'b1;
                        fetch_pc_d = block_base + 64'(FETCH_BYTES);
                        state_d    = ST_IDLE;
                    end
                end
                ST_KILL: if (icache_resp_valid) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            valid_q <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= deliver ? shifted_mask : '0;
            done_q  <= deliver;
            if (deliver) begin
                instr_q <= shifted;
                pc_q    <= fetch_pc_q;
            end
        end
    end

    assign icache_req_valid    = (state_q == ST_REQ);
    assign icache_req_addr     = block_base;
    assign aligned_instr       = instr_q;
    assign aligned_instr_valid = valid_q;
    assign pc                  = pc_q;
    assign pc_operation_done   = done_q;

endmodule
